// File: rtl/ecc_pkg.sv
// Shared types for sequencers driving the F_2^7 point adder.
// Point layout is {y[6:0], x[6:0]}; all-zero encodes infinity.
package ecc_pkg;

  localparam int COORD_W = 7;
  localparam int POINT_W = 2 * COORD_W;

  typedef logic [POINT_W-1:0] point_t;

  localparam point_t POINT_INF = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } acc_state_t;

  function automatic logic is_inf(point_t p);
    return p == POINT_INF;
  endfunction

endpackage

// File: rtl/ecc_wait_timer.sv
// Fixed-latency wait timer for the external point adder.
// Start pulse arms it; expire pulses in the cycle ending ADD_LAT after start.
module ecc_wait_timer #(
  parameter int ADD_LAT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_expire
);

  localparam int CW = $clog2(ADD_LAT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_running;

  assign w_running = (r_cnt != '0);
  assign o_expire  = (r_cnt == CW'(ADD_LAT));

  // count 1..ADD_LAT after the start cycle, then idle at zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(1);
    end else if (o_expire) begin
      r_cnt <= '0;
    end else if (w_running) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/point_accumulator.sv
// Running group-sum sequencer in front of the F_2^7 point adder.
// Optional beat counter (out_count) enabled by POINT_ACC_COUNT_EN.
module point_accumulator
  import ecc_pkg::*;
#(
  parameter int ADD_LAT = 4
`ifdef POINT_ACC_COUNT_EN
  , parameter int COUNT_W = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [POINT_W-1:0] in_point,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POINT_W-1:0] out_point,
`ifdef POINT_ACC_COUNT_EN
  output logic [COUNT_W-1:0] out_count,
`endif
  output logic [POINT_W-1:0] add_p1,
  output logic [POINT_W-1:0] add_p2,
  output logic               add_load,
  input  logic [POINT_W-1:0] add_sum
);

  acc_state_t r_state;
  acc_state_t w_state_nxt;
  point_t     r_acc;
  point_t     r_op;
  logic       r_last;
  logic       w_accept;
  logic       w_trivial;
  logic       w_start;
  logic       w_expire;
  logic       w_out_done;

  assign w_accept   = in_valid & (r_state == ST_IDLE);
  assign w_trivial  = is_inf(in_point) | is_inf(r_acc);
  assign w_out_done = out_ready & (r_state == ST_OUT);

  assign add_p1    = r_acc;
  assign add_p2    = r_op;
  assign out_point = r_acc;

  ecc_wait_timer #(
    .ADD_LAT (ADD_LAT)
  ) u_timer (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (w_start),
    .o_expire (w_expire)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state and handshake/adder strobes
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    add_load    = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!w_trivial)   w_state_nxt = ST_ISSUE;
          else if (in_last) w_state_nxt = ST_OUT;
        end
      end
      ST_ISSUE: begin
        add_load    = 1'b1;
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_expire)
          w_state_nxt = r_last ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // accumulator, operand and batch-close flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= POINT_INF;
      r_op   <= POINT_INF;
      r_last <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= in_point;
        r_last <= in_last;
        if (!is_inf(in_point) && is_inf(r_acc))
          r_acc <= in_point;
      end else if (r_state == ST_WAIT && w_expire) begin
        r_acc <= add_sum;
      end else if (w_out_done) begin
        r_acc <= POINT_INF;
      end
    end
  end

`ifdef POINT_ACC_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  assign out_count = r_count;

  // saturating count of accepted beats in the open batch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (r_count != '1) r_count <= r_count + COUNT_W'(1);
    end else if (w_out_done) begin
      r_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_point_accumulator.sv
// Bench for point_accumulator with a behavioural F_2^7 adder model.
// Build with POINT_ACC_COUNT_EN defined to also check out_count.
module tb_point_accumulator;

  localparam int ADD_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_point;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_point;
  logic [13:0] add_p1;
  logic [13:0] add_p2;
  logic        add_load;
  logic [13:0] add_sum = 14'h0;
`ifdef POINT_ACC_COUNT_EN
  logic [7:0]  out_count;
`endif

  point_accumulator #(
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_point  (in_point),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_point (out_point),
`ifdef POINT_ACC_COUNT_EN
    .out_count (out_count),
`endif
    .add_p1    (add_p1),
    .add_p2    (add_p2),
    .add_load  (add_load),
    .add_sum   (add_sum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // GF(2^7) with x^7+x+1, curve y^2+xy = x^3+x^2+b (a=1)
  function automatic logic [6:0] gf_mul(logic [6:0] a, logic [6:0] b);
    logic [7:0] t;
    logic [6:0] r;
    t = {1'b0, a};
    r = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) r ^= t[6:0];
      t = t << 1;
      if (t[7]) t ^= 8'h83;
    end
    return r;
  endfunction

  function automatic logic [6:0] gf_inv(logic [6:0] a);
    logic [6:0] r;
    logic [6:0] s;
    r = 7'h1;
    s = a;
    for (int i = 0; i < 6; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // adder rules: infinity is identity, equal x gives infinity
  function automatic logic [13:0] ec_add(logic [13:0] p, logic [13:0] q);
    logic [6:0] x1, y1, x2, y2, lam, x3, y3;
    if (p == 14'h0) return q;
    if (q == 14'h0) return p;
    x1 = p[6:0];  y1 = p[13:7];
    x2 = q[6:0];  y2 = q[13:7];
    if (x1 == x2) return 14'h0;
    lam = gf_mul(y1 ^ y2, gf_inv(x1 ^ x2));
    x3  = gf_mul(lam, lam) ^ lam ^ x1 ^ x2 ^ 7'h1;
    y3  = gf_mul(lam, x1 ^ x3) ^ x3 ^ y1;
    return {y3, x3};
  endfunction

  // adder model: result presented only for the capture edge
  logic [13:0] m_res;
  logic [13:0] m_p1;
  logic [13:0] m_p2;
  int          m_k = 0;
  bit          m_pend = 0;
  bit          m_abort = 0;
  bit          prev_load = 0;
  int          loads = 0;
  int          last_load_cyc = -100;

  always @(negedge clk) begin
    if (add_load === 1'b1) begin
      chk("load_one_cycle", {31'd0, prev_load}, 32'd0);
      chk("load_spacing", {31'd0, (cyc - last_load_cyc) >= 2 + ADD_LAT},
          32'd1);
      m_pend = 1;
      m_k = 0;
      m_p1 = add_p1;
      m_p2 = add_p2;
      m_res = ec_add(add_p1, add_p2);
      loads++;
      last_load_cyc = cyc;
    end
    prev_load = (add_load === 1'b1);
    if (m_pend && add_load !== 1'b1) begin
      m_k++;
      if (!m_abort) begin
        chk("p1_stable", {18'd0, add_p1}, {18'd0, m_p1});
        chk("p2_stable", {18'd0, add_p2}, {18'd0, m_p2});
      end
    end
    if (m_pend && m_k == ADD_LAT) begin
      add_sum = m_res;
      m_pend = 0;
      m_abort = 0;
    end else begin
      add_sum = 14'($urandom);
    end
  end

  logic [13:0] m_acc = 14'h0;
  int          m_cnt = 0;
  int          exp_loads = 0;

  task automatic send(input logic [13:0] p, input logic last,
                      input bit hold);
    int w;
    in_valid = 1'b1;
    in_point = p;
    in_last  = last;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", {31'd0, w < 40}, 32'd1);
    @(posedge clk);
    if (m_acc != 14'h0 && p != 14'h0) exp_loads++;
    m_acc = ec_add(m_acc, p);
    m_cnt++;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic get_out(input bit chk_lat, input int hold_cyc);
    int w;
    logic [13:0] held;
    w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("out_timeout", {31'd0, out_valid}, 32'd1);
    if (chk_lat)
      chk("out_latency", cyc - last_load_cyc, ADD_LAT + 1);
    chk("out_point", {18'd0, out_point}, {18'd0, m_acc});
    chk("in_ready_in_out", {31'd0, in_ready}, 32'd0);
    chk("load_count", loads, exp_loads);
`ifdef POINT_ACC_COUNT_EN
    chk("out_count", {24'd0, out_count}, m_cnt > 255 ? 255 : m_cnt);
`endif
    held = out_point;
    repeat (hold_cyc) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_point", {18'd0, out_point}, {18'd0, held});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    m_acc = 14'h0;
    m_cnt = 0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_drop", {31'd0, out_valid}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [13:0] p;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_point  = 14'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_add_load", {31'd0, add_load}, 32'd0);
    chk("rst_out_point", {18'd0, out_point}, 32'd0);
    chk("rst_p1", {18'd0, add_p1}, 32'd0);
    chk("rst_p2", {18'd0, add_p2}, 32'd0);
    @(negedge clk);

    // single point closes batch with no adder op
    send(14'h0A5B, 1'b1, 1'b0);
    chk("single_fast", {31'd0, out_valid}, 32'd1);
    get_out(1'b0, 0);

    // one real add, zero point ignored
    send(14'h0A5B, 1'b0, 1'b0);
    send(14'h0000, 1'b0, 1'b0);
    send(14'h1234, 1'b1, 1'b0);
    chk("issue_p1", {18'd0, add_p1}, 32'h0A5B);
    chk("issue_p2", {18'd0, add_p2}, 32'h1234);
    get_out(1'b1, 0);

    // equal x collapses to infinity
    send(14'h0A5B, 1'b0, 1'b0);
    send(14'h0A5B, 1'b1, 1'b0);
    get_out(1'b1, 0);
    chk("equal_x_zero", {18'd0, m_acc}, 32'd0);

    // lone zero point closes batch with zero
    send(14'h0000, 1'b1, 1'b0);
    get_out(1'b0, 0);

    // consumer stalls for six cycles
    send(14'h0155, 1'b0, 1'b0);
    send(14'h2A21, 1'b1, 1'b0);
    get_out(1'b1, 6);
    send(14'h3003, 1'b1, 1'b0);
    get_out(1'b0, 0);

    // reset in the middle of an adder wait
    send(14'h0A5B, 1'b0, 1'b0);
    send(14'h1234, 1'b0, 1'b0);
    @(negedge clk);
    m_abort = 1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_acc = 14'h0;
    m_cnt = 0;
    chk("wrst_ready", {31'd0, in_ready}, 32'd1);
    chk("wrst_load", {31'd0, add_load}, 32'd0);
    chk("wrst_acc", {18'd0, out_point}, 32'd0);
    chk("wrst_valid", {31'd0, out_valid}, 32'd0);
    send(14'h0777, 1'b1, 1'b0);
    get_out(1'b0, 0);
    repeat (4) @(negedge clk);
    chk("late_sum_ignored", {18'd0, out_point}, 32'd0);

    // back-to-back random batches with in_valid held high
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        p = ($urandom_range(0, 9) == 0) ? 14'h0 : 14'($urandom);
        send(p, i == 9, i != 9);
      end
      get_out(1'b0, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
